// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared MMIO offsets, STATUS bit positions and default bases
package mips_mem_pkg;
  localparam logic [31:0] CON_TX_OFS    = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS    = 32'h0000_0004;
  localparam int          STAT_FULL      = 0;
  localparam int          STAT_EMPTY     = 1;
  localparam int          STAT_OVF       = 2;
  localparam int          STAT_RNG_ERR   = 3;
  localparam int          STAT_COUNT_LSB = 8;
  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_1000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;
endpackage

// File: rtl/con_fifo.sv
// rtl/con_fifo.sv - parameterised synchronous console FIFO with push, pop, full, empty and count
module con_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO only lands when the same edge frees a slot.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem[rd_ptr_q];
endmodule

// File: rtl/harvard_data_mem.sv
// rtl/harvard_data_mem.sv - data-side RAM responder with MMIO console window
// Console FIFO and CON_TX/STATUS decode exist only with HARVARD_DATA_MEM_CONSOLE_EN defined.
module harvard_data_mem
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = DEF_MMIO_BASE,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]      addr_w, ram_off, mmio_rdata;
  logic             ram_hit, wr_en, unmapped, rng_clr;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_mem [DEPTH_WORDS];
  logic             rng_err_q, rng_err_d;
  logic             unused_bits;

  always_comb begin
    addr_w  = {data_address[31:2], 2'b00};
    ram_off = addr_w - RAM_BASE;
    ram_hit = (addr_w >= RAM_BASE) && (ram_off < RAM_BYTES);
    ram_idx = ram_off[IDX_W+1:2];
  end

  assign wr_en       = clk_enable && data_write;
  assign unused_bits = ^{data_address[1:0], ram_off[1:0], ram_off[31:IDX_W+2]};

  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) ram_mem[ram_idx] <= data_writedata;
  end

  assign data_readdata = ram_hit ? ram_mem[ram_idx] : mmio_rdata;

`ifdef HARVARD_DATA_MEM_CONSOLE_EN
  logic                        con_hit, stat_hit, fifo_push, fifo_pop;
  logic                        fifo_full, fifo_empty, ovf_q, ovf_d;
  logic [7:0]                  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign con_hit   = (addr_w == MMIO_BASE + CON_TX_OFS);
  assign stat_hit  = (addr_w == MMIO_BASE + STATUS_OFS);
  assign fifo_push = wr_en && con_hit;
  assign fifo_pop  = con_valid && con_ready;

  con_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_con_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (data_writedata[7:0]),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_head;
  assign unmapped  = !ram_hit && !con_hit && !stat_hit;
  assign rng_clr   = wr_en && stat_hit && data_writedata[STAT_RNG_ERR];

  always_comb begin
    mmio_rdata = '0;
    if (stat_hit) begin
      mmio_rdata[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
      mmio_rdata[STAT_RNG_ERR]        = rng_err_q;
      mmio_rdata[STAT_OVF]            = ovf_q;
      mmio_rdata[STAT_EMPTY]          = fifo_empty;
      mmio_rdata[STAT_FULL]           = fifo_full;
    end
    // A push dropped only when no pop frees a slot on the same edge.
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_en && stat_hit && data_writedata[STAT_OVF]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
`else
  logic unused_con;

  assign con_valid  = 1'b0;
  assign con_data   = 8'h00;
  assign mmio_rdata = '0;
  assign unmapped   = !ram_hit;
  assign rng_clr    = 1'b0;
  assign unused_con = con_ready;
`endif

  always_comb begin
    rng_err_d = rng_err_q;
    if (rng_clr) rng_err_d = 1'b0;
    if (clk_enable && (data_read || data_write) && unmapped) rng_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rng_err_q <= 1'b0;
    else          rng_err_q <= rng_err_d;
  end
endmodule
